// File: rtl/lfsr_checker.sv
`timescale 1ns/1ps
// lfsr_checker
// Receive-side checker for the 8-bit Fibonacci LFSR pattern stream
// (taps s[4]^s[3]^s[2]^s[0], right shift, feedback into bit 7).
// It fills an 8-bit history from the incoming bits, then predicts each new
// bit from that history. After LOCK_CNT correct predictions in a row it
// declares lock. While locked it runs on its own predictions and counts
// bit errors. After LOSS_CNT consecutive misses it drops back to searching.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [31:0] bit_cnt
);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    // Next stream bit predicted from the last eight received bits.
    // h[0] holds the oldest bit: b[n+8] = b[n+4]^b[n+3]^b[n+2]^b[n].
    function automatic logic lfsr_pred(input logic [7:0] hist);
        return hist[4] ^ hist[3] ^ hist[2] ^ hist[0];
    endfunction

    state_t      state_r;
    logic [7:0]  h_r;
    logic [3:0]  fill_cnt_r;
    logic [7:0]  match_cnt_r;
    logic [3:0]  miss_cnt_r;

    logic        pred_s;
    logic        mismatch_s;
    logic        hist_zero_s;
    logic        check_s;
    logic        err_hit_s;
    logic [7:0]  match_inc_s;
    logic [3:0]  miss_inc_s;

    // Prediction and compare terms shared by the FSM and the counters.
    always_comb begin
        pred_s      = lfsr_pred(h_r);
        mismatch_s  = in_bit ^ pred_s;
        hist_zero_s = (h_r == 8'd0);
        match_inc_s = match_cnt_r + 8'd1;
        miss_inc_s  = miss_cnt_r + 4'd1;
        if (in_valid && (state_r == ST_LOCKED)) begin
            check_s = 1'b1;
        end else begin
            check_s = 1'b0;
        end
        err_hit_s = check_s & mismatch_s;
    end

    // Search/lock FSM with history register and registered lock output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_SEARCH;
            locked      <= 1'b0;
            h_r         <= 8'd0;
            fill_cnt_r  <= 4'd0;
            match_cnt_r <= 8'd0;
            miss_cnt_r  <= 4'd0;
        end else if (in_valid) begin
            case (state_r)
                ST_SEARCH: begin
                    h_r <= {in_bit, h_r[7:1]};
                    if (fill_cnt_r < 4'd8) begin
                        fill_cnt_r <= fill_cnt_r + 4'd1;
                    end else if (!mismatch_s && !hist_zero_s) begin
                        // The all-zero history is the LFSR lock-up state and
                        // predicts zeros forever, so it never counts toward lock.
                        if (match_inc_s == LOCK_TGT) begin
                            state_r     <= ST_LOCKED;
                            locked      <= 1'b1;
                            match_cnt_r <= 8'd0;
                            miss_cnt_r  <= 4'd0;
                        end else begin
                            match_cnt_r <= match_inc_s;
                        end
                    end else begin
                        match_cnt_r <= 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the history advances on the prediction, so a
                    // corrupted received bit never pollutes later predictions.
                    h_r <= {pred_s, h_r[7:1]};
                    if (mismatch_s) begin
                        if (miss_inc_s == LOSS_TGT) begin
                            state_r     <= ST_SEARCH;
                            locked      <= 1'b0;
                            fill_cnt_r  <= 4'd0;
                            match_cnt_r <= 8'd0;
                            miss_cnt_r  <= 4'd0;
                        end else begin
                            miss_cnt_r <= miss_inc_s;
                        end
                    end else begin
                        miss_cnt_r <= 4'd0;
                    end
                end
                default: begin
                    state_r     <= ST_SEARCH;
                    locked      <= 1'b0;
                    fill_cnt_r  <= 4'd0;
                    match_cnt_r <= 8'd0;
                    miss_cnt_r  <= 4'd0;
                end
            endcase
        end
    end

    // Error strobe and saturating error/bit counters; clear wins over increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_cnt   <= 16'd0;
            bit_cnt   <= 32'd0;
        end else begin
            err_pulse <= err_hit_s;
            if (clear) begin
                err_cnt <= 16'd0;
                bit_cnt <= 32'd0;
            end else begin
                if (check_s && (bit_cnt != 32'hFFFF_FFFF)) begin
                    bit_cnt <= bit_cnt + 32'd1;
                end
                if (err_hit_s && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
`timescale 1ns/1ps
// Testbench for lfsr_checker: generator-driven directed scenarios plus
// randomized gaps and errors, checked against a queue-based reference model.
module tb_lfsr_checker;

    localparam int LOCK_N = 16;
    localparam int LOSS_N = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;

    int checks;
    int failures;

    // reference model state
    int          hist[$];
    int          m_locked;
    int          m_fill;
    int          m_streak;
    int          m_miss;
    int          m_pulse;
    logic [15:0] m_err;
    logic [31:0] m_bits;

    // generator state and scratch
    int   g;
    logic b;
    int   n;
    int   e;

    lfsr_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(0);
        m_locked = 0; m_fill = 0; m_streak = 0; m_miss = 0; m_pulse = 0;
        m_err = 16'd0; m_bits = 32'd0;
    endtask

    // One clock of the checker behaviour, stated directly from the stream rules.
    task automatic model_step(input logic v, input logic bi, input logic c);
        int p;
        int s;
        m_pulse = 0;
        if (v) begin
            p = (hist[0] + hist[2] + hist[3] + hist[4]) % 2;
            s = 0;
            foreach (hist[i]) s += hist[i];
            if (m_locked == 0) begin
                if (m_fill < 8) m_fill++;
                else if (int'(bi) == p && s != 0) begin
                    m_streak++;
                    if (m_streak == LOCK_N) begin
                        m_locked = 1; m_streak = 0; m_miss = 0;
                    end
                end else m_streak = 0;
                hist.push_back(int'(bi));
            end else begin
                hist.push_back(p);
                if (m_bits != 32'hFFFF_FFFF) m_bits = m_bits + 32'd1;
                if (int'(bi) != p) begin
                    m_pulse = 1;
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    m_miss++;
                    if (m_miss == LOSS_N) begin
                        m_locked = 0; m_fill = 0; m_streak = 0; m_miss = 0;
                    end
                end else m_miss = 0;
            end
            void'(hist.pop_front());
        end
        if (c) begin
            m_err = 16'd0;
            m_bits = 32'd0;
        end
    endtask

    // Next bit of the reference pattern generator (s[0], then shift).
    task automatic next_gen(output logic ob);
        int fb;
        ob = logic'(g & 1);
        fb = ((g >> 4) ^ (g >> 3) ^ (g >> 2) ^ g) & 1;
        g = (g >> 1) | (fb << 7);
    endtask

    // Drive one cycle, advance the model, compare all outputs after the edge.
    task automatic send(input logic v, input logic bi, input logic c);
        @(negedge clk);
        in_valid = v; in_bit = bi; clear = c;
        @(posedge clk);
        model_step(v, bi, c);
        #1;
        chk("locked",    32'(locked),    32'(m_locked));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_cnt",   32'(err_cnt),   32'(m_err));
        chk("bit_cnt",   bit_cnt,        m_bits);
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
        checks = 0; failures = 0; g = 1;
        model_reset();
        #12;
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_bit_cnt",   bit_cnt,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // all-zero stream must never lock
        repeat (100) send(1'b1, 1'b0, 1'b0);
        chk("zeros_locked",  32'(locked),  32'd0);
        chk("zeros_err_cnt", 32'(err_cnt), 32'd0);

        // clean stream seeded 8'h01, continuous valid
        do_reset();
        g = 8'h01; n = 0;
        while (!locked && n < 100) begin next_gen(b); send(1'b1, b, 1'b0); n++; end
        chk("lock_point", 32'(n), 32'd24);
        repeat (1000) begin next_gen(b); send(1'b1, b, 1'b0); end
        chk("clean_err_cnt", 32'(err_cnt), 32'd0);
        chk("clean_bit_cnt", bit_cnt, 32'd1000);

        // single inverted bit while locked
        next_gen(b); send(1'b1, ~b, 1'b0);
        chk("single_pulse",  32'(err_pulse), 32'd1);
        chk("single_err",    32'(err_cnt),   32'd1);
        chk("single_locked", 32'(locked),    32'd1);
        repeat (255) begin next_gen(b); send(1'b1, b, 1'b0); end
        chk("single_after_err", 32'(err_cnt), 32'd1);
        chk("single_after_lck", 32'(locked),  32'd1);

        // clear on an idle cycle
        send(1'b0, 1'b0, 1'b1);
        chk("clear_err", 32'(err_cnt), 32'd0);
        chk("clear_bit", bit_cnt, 32'd0);

        // four consecutive errors drop lock
        for (int i = 0; i < 4; i++) begin
            next_gen(b); send(1'b1, ~b, 1'b0);
            if (i < 3) chk("burst_still_locked", 32'(locked), 32'd1);
        end
        chk("loss_locked", 32'(locked),    32'd0);
        chk("loss_pulse",  32'(err_pulse), 32'd1);
        chk("loss_err",    32'(err_cnt),   32'd4);
        chk("loss_bits",   bit_cnt,        32'd4);
        n = 0;
        while (!locked && n < 100) begin next_gen(b); send(1'b1, b, 1'b0); n++; end
        chk("relock_point", 32'(n), 32'd24);

        // same stream with random valid gaps
        do_reset();
        g = 8'h01; n = 0;
        while (!locked && n < 100) begin
            repeat ($urandom_range(0, 5)) send(1'b0, 1'b0, 1'b0);
            next_gen(b); send(1'b1, b, 1'b0); n++;
        end
        chk("gap_lock_point", 32'(n), 32'd24);
        repeat (200) begin
            repeat ($urandom_range(0, 5)) send(1'b0, 1'b0, 1'b0);
            next_gen(b); send(1'b1, b, 1'b0);
        end
        chk("gap_err_cnt", 32'(err_cnt), 32'd0);

        // clear alongside an injected error
        next_gen(b); send(1'b1, ~b, 1'b1);
        chk("clr_err_cnt",  32'(err_cnt),   32'd0);
        chk("clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_bit_cnt",  bit_cnt,        32'd0);

        // three isolated errors, then asynchronous reset
        repeat (3) begin
            next_gen(b); send(1'b1, ~b, 1'b0);
            repeat (5) begin next_gen(b); send(1'b1, b, 1'b0); end
        end
        chk("three_err", 32'(err_cnt), 32'd3);
        chk("three_lck", 32'(locked),  32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_locked", 32'(locked),    32'd0);
        chk("async_err",    32'(err_cnt),   32'd0);
        chk("async_bits",   bit_cnt,        32'd0);
        chk("async_pulse",  32'(err_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        g = int'($urandom_range(1, 255)); n = 0;
        while (!locked && n < 100) begin next_gen(b); send(1'b1, b, 1'b0); n++; end
        chk("reset_relock_point", 32'(n), 32'd24);

        // random errors and gaps, tracked cycle by cycle by the model
        repeat (400) begin
            repeat ($urandom_range(0, 2)) send(1'b0, 1'b0, 1'b0);
            e = ($urandom_range(0, 7) == 0) ? 1 : 0;
            next_gen(b); send(1'b1, b ^ logic'(e), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial receive-side checker for the 8-bit Fibonacci LFSR pattern generator used across the lab designs (feedback `s[4]^s[3]^s[2]^s[0]`, right shift, feedback into bit 7). It consumes the generator's shifted-out bit stream (`s[0]` before each step) one bit per `in_valid` strobe. It self-synchronises to that stream, declares lock, then flywheels on its own prediction to count bit errors. Its status and counters drive the board LEDs and seven-segment display logic.

## Interface
- `LOCK_CNT`, default 16: consecutive predicted-correct bits required to enter LOCKED (range 1..255).
- `LOSS_CNT`, default 4: consecutive mismatches in LOCKED that force a return to SEARCH (range 1..15).

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  qualifies `in_bit`; exactly one bit is consumed per high cycle.
- `in_bit`  in  1  received serial bit.
- `clear`  in  1  synchronous clear of `err_cnt` and `bit_cnt`; lock state is unaffected.
- `locked`  out  1  high while the FSM is in LOCKED.
- `err_pulse`  out  1  one-cycle strobe for each mismatched bit while LOCKED.
- `err_cnt`  out  16  saturating count of mismatches while LOCKED.
- `bit_cnt`  out  32  saturating count of valid bits checked while LOCKED, errored bits included.

## Operation
- History register `h[7:0]`; a new bit enters at `h[7]` via `h <= {x, h[7:1]}`. Prediction is `pred = h[4]^h[3]^h[2]^h[0]`, computed from `h` before the update.
  - This holds because for the generator stream, `b[n+8] = b[n+4]^b[n+3]^b[n+2]^b[n]`.
- Internal state: `fill_cnt` (0..8), `match_cnt` (8 bit), `miss_cnt` (4 bit).
- The FSM has two states: SEARCH and LOCKED. Reset enters SEARCH.
- SEARCH, on each `in_valid` cycle:
  - `h` always takes `in_bit`.
  - While `fill_cnt < 8`: increment `fill_cnt`; no compare is made.
  - Once `fill_cnt == 8`:
    - If `in_bit == pred` and the old `h != 0`: increment `match_cnt`.
    - Otherwise: `match_cnt <= 0`.
    - The all-zero history is the LFSR lock-up state and must never count toward lock.
  - When an increment makes `match_cnt == LOCK_CNT`, the FSM goes to LOCKED. On that transition, `match_cnt <= 0` and `miss_cnt <= 0`.
- LOCKED, on each `in_valid` cycle:
  - `h` takes `pred` (flywheel), so a received error does not propagate into later predictions.
  - `bit_cnt` increments, saturating at `32'hFFFF_FFFF`.
  - On mismatch: assert `err_pulse`, increment `err_cnt` (saturating at `16'hFFFF`), increment `miss_cnt`.
  - On match: `miss_cnt <= 0`.
  - When a mismatch makes `miss_cnt == LOSS_CNT`, the FSM goes to SEARCH with `fill_cnt <= 0`, `match_cnt <= 0`, `miss_cnt <= 0`. `h` is retained but is refilled by the next 8 bits.
- Cycles with `in_valid` low: no state change, `err_pulse` low.
- `clear` high: `err_cnt <= 0` and `bit_cnt <= 0`; clear takes priority over any same-cycle increment. `err_pulse` and the FSM still respond normally to that cycle's bit.

## Timing
- Every output is a flop output; there are no combinational input-to-output paths.
- Reset (asynchronous, effective immediately while `rst_n` is low) drives:
  - outputs: `locked=0`, `err_pulse=0`, `err_cnt=0`, `bit_cnt=0`;
  - internal state: `h=0`, `fill_cnt=0`, `match_cnt=0`, `miss_cnt=0`, FSM in SEARCH.
- Reset asserted mid-lock drops `locked` without waiting for a clock edge.
- Latency: `err_pulse`, `err_cnt`, `bit_cnt` and `locked` reflect the bit sampled at edge k in the cycle following edge k.
- From a clean, error-free stream after reset, the minimum lock time is `8 + LOCK_CNT` valid bits. `locked` rises the cycle after the `(8+LOCK_CNT)`th valid bit.
- Loss of lock: `locked` falls the cycle after the `LOSS_CNT`th consecutive mismatch. `err_pulse` is also high in that same cycle, and that bit is counted in `err_cnt` and `bit_cnt`.
- There is no throughput limit: `in_valid` may be high every cycle, and gaps of any length are tolerated.

## Test plan
- Drive the generator stream seeded `8'h01` (first bits 1,0,0,0,0,0,0,0,…) with `in_valid` continuous -> `locked` rises after the 24th bit; after 1000 more bits, `err_cnt=0` and `bit_cnt=1000`.
- Drive 100 zero bits after reset -> `locked` stays 0 and `err_cnt=0`.
- Once locked, invert a single bit -> exactly one `err_pulse`, `err_cnt=1`, `locked` stays 1, and the following 255 bits add no errors.
- Once locked, invert 4 consecutive bits -> `err_cnt=4`, `locked` falls the cycle after the 4th; a clean stream afterwards relocks after 24 more valid bits.
- Repeat the first scenario with random `in_valid` gaps of 0–5 cycles -> identical lock point (in valid bits) and `err_cnt=0`. Pulse `clear` alongside an injected error -> `err_cnt=0` and `err_pulse=1` in the next cycle.
- Assert `rst_n` low asynchronously while locked with `err_cnt=3` -> `locked=0` and `err_cnt=0` before the next clock edge; after release, lock is reacquired after 24 valid bits.
